// File: rtl/cla_share_arb_pkg.sv
// Shared types and helpers for the cla_share_arb adder-sharing block.
// Contents: lock-state encoding, requester count, legal-width check.
package cla_share_arb_pkg;

   localparam int unsigned NUM_REQ = 2;

   // Adder ownership state: free for round-robin, or locked to one requester.
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCK0    = 2'd1,
      LOCK1    = 2'd2
   } lock_state_e;

   // The shared adder is only built for these widths.
   function automatic bit width_legal(input int unsigned w);
      return (w == 32) || (w == 64) || (w == 128);
   endfunction

endpackage

// File: rtl/cla_share_arb_if.sv
// Request/response bundle between the two requesters and cla_share_arb.
// Request side : req_valid/req_ready handshake, operands req_a/req_b packed
//                per requester at [i*WIDTH +: WIDTH], req_ci, req_sub, req_chain.
// Response side: one-hot resp_valid, per-requester resp_ready, resp_sum, resp_co.
// master = requesters, slave = arbiter.
interface cla_share_arb_if
   import cla_share_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 64
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_ci;
   logic [NUM_REQ-1:0]       req_sub;
   logic [NUM_REQ-1:0]       req_chain;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [NUM_REQ-1:0]       resp_ready;
   logic [WIDTH-1:0]         resp_sum;
   logic                     resp_co;

   modport master (
      output req_valid, req_a, req_b, req_ci, req_sub, req_chain, resp_ready,
      input  req_ready, resp_valid, resp_sum, resp_co
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ci, req_sub, req_chain, resp_ready,
      output req_ready, resp_valid, resp_sum, resp_co
   );

endinterface

// File: rtl/CLA.sv
// Carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Ports: a, b operands, ci carry-in, s sum, co carry-out.
module CLA #(
   parameter int unsigned WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   localparam int unsigned BLK  = 4;
   localparam int unsigned NBLK = WIDTH / BLK;

   // Whole adder as one function so the carry chain lives in locals only.
   function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             cin);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] sum;
      logic [BLK-1:0]   gg;
      logic [BLK-1:0]   pp;
      logic [BLK:0]     bc;
      logic             blk_g;
      logic             blk_p;
      logic             c;
      g   = x & y;
      p   = x ^ y;
      sum = '0;
      c   = cin;
      for (int unsigned k = 0; k < NBLK; k++) begin
         gg    = g[k*BLK +: BLK];
         pp    = p[k*BLK +: BLK];
         blk_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0]);
         blk_p = &pp;
         bc[0] = c;
         bc[1] = gg[0] | (pp[0] & c);
         bc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
         bc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & c);
         bc[4] = blk_g | (blk_p & c);
         sum[k*BLK +: BLK] = pp ^ bc[BLK-1:0];
         c = bc[4];
      end
      return {c, sum};
   endfunction

   assign {co, s} = cla_add(a, b, ci);

endmodule

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin arbiter with lock override.
// Ports: req[1:0] requests, last = index granted most recently,
//        lock_en/lock_id force the grant to one requester, grant[1:0] one-hot.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       lock_en,
   input  logic       lock_id,
   output logic [1:0] grant
);

   // While locked the other requester is never granted, even if idle owner.
   always_comb begin
      grant = 2'b00;
      if (lock_en) begin
         grant[lock_id] = req[lock_id];
      end else begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/cla_share_arb.sv
// Arbiter/sequencer sharing one CLA between two requesters: round-robin
// grant, subtraction, carry-chained locked sequences, and a one-entry
// registered result stage with per-requester backpressure.
// Ports: clk, rst_n (async, active-low), bus (cla_share_arb_if.slave).
module cla_share_arb
   import cla_share_arb_pkg::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   cla_share_arb_if.slave bus
);

   if (!width_legal(WIDTH)) begin : g_width_chk
      $error("cla_share_arb: WIDTH must be 32, 64 or 128");
   end

   lock_state_e      state_q;
   lock_state_e      state_d;
   logic             carry_q;
   logic             last_q;
   logic [1:0]       resp_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;

   logic [1:0]       grant;
   logic             lock_en;
   logic             lock_id;
   logic             out_valid;
   logic             owner;
   logic             drain;
   logic             slot_free;
   logic             accept;
   logic             sel;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] op_b_eff;
   logic             op_ci;
   logic             op_sub;
   logic             op_chain;
   logic             ci_eff;
   logic [WIDTH-1:0] sum;
   logic             co;

   assign lock_en = (state_q != UNLOCKED);
   assign lock_id = (state_q == LOCK1);

   rr_arb2 u_arb (
      .req     (bus.req_valid),
      .last    (last_q),
      .lock_en (lock_en),
      .lock_id (lock_id),
      .grant   (grant)
   );

   // Result slot can take a new beat when empty or being drained this cycle.
   assign out_valid     = |resp_valid_q;
   assign owner         = resp_valid_q[1];
   assign drain         = out_valid & bus.resp_ready[owner];
   assign slot_free     = ~out_valid | drain;
   assign bus.req_ready = {2{rst_n}} & grant & {2{slot_free}};
   assign accept        = |(bus.req_valid & bus.req_ready);
   assign sel           = grant[1];

   // Operand select from the granted requester.
   assign op_a     = sel ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH];
   assign op_b     = sel ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH];
   assign op_ci    = bus.req_ci[sel];
   assign op_sub   = bus.req_sub[sel];
   assign op_chain = bus.req_chain[sel];

   // Continuation beats take the stored carry; ci and the sub-forced 1 are ignored.
   assign op_b_eff = op_sub ? ~op_b : op_b;
   assign ci_eff   = lock_en ? carry_q : (op_sub | op_ci);

   CLA #(.WIDTH(WIDTH)) u_cla (
      .a  (op_a),
      .b  (op_b_eff),
      .ci (ci_eff),
      .s  (sum),
      .co (co)
   );

   // Lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= UNLOCKED;
      else        state_q <= state_d;
   end

   // Lock next state: chain=1 locks to the granted requester, chain=0 releases.
   always_comb begin
      state_d = state_q;
      if (accept) begin
         if (op_chain) state_d = sel ? LOCK1 : LOCK0;
         else          state_d = UNLOCKED;
      end
   end

   // Carry, round-robin history and the one-entry result stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q      <= 1'b0;
         last_q       <= 1'b1;
         resp_valid_q <= 2'b00;
         sum_q        <= '0;
         co_q         <= 1'b0;
      end else if (accept) begin
         carry_q      <= co;
         last_q       <= sel;
         resp_valid_q <= sel ? 2'b10 : 2'b01;
         sum_q        <= sum;
         co_q         <= co;
      end else if (drain) begin
         resp_valid_q <= 2'b00;
      end
   end

   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_sum   = sum_q;
   assign bus.resp_co    = co_q;

endmodule

// File: tb/tb_cla_share_arb.sv
// Directed bench for cla_share_arb at WIDTH=64: reset, add, sub, contention,
// chained add/sub, backpressure and reset in the middle of a locked chain.
module tb_cla_share_arb;

   localparam int unsigned W = 64;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;
   logic [W-1:0] ones;

   cla_share_arb_if #(.WIDTH(W)) bus ();

   cla_share_arb #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input logic chain);
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
      bus.req_ci[i]       = ci;
      bus.req_sub[i]      = sub;
      bus.req_chain[i]    = chain;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic chk_resp(input string tag, input logic [1:0] v, input logic [W-1:0] s,
                           input logic c);
      chk({tag, ".valid"}, 128'(bus.resp_valid), 128'(v));
      chk({tag, ".sum"},   128'(bus.resp_sum),   128'(s));
      chk({tag, ".co"},    128'(bus.resp_co),    128'(c));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      ones        = '1;
      rst_n       = 1'b0;
      bus.req_valid  = 2'b11;
      bus.resp_ready = 2'b11;
      set_req(0, ones, 64'd1, 1'b0, 1'b0, 1'b0);
      set_req(1, 64'd5, 64'd7, 1'b0, 1'b1, 1'b0);

      // Reset held with both requesters valid
      cyc();
      cyc();
      mid();
      chk("rst.req_ready",  128'(bus.req_ready),  128'(2'b00));
      chk("rst.resp_valid", 128'(bus.resp_valid), 128'(2'b00));
      chk("rst.resp_sum",   128'(bus.resp_sum),   128'(0));
      chk("rst.resp_co",    128'(bus.resp_co),    128'(0));
      cyc();
      rst_n = 1'b1;
      mid();
      chk("first.grant", 128'(bus.req_ready), 128'(2'b01));

      // Add: all-ones + 1
      cyc();
      chk_resp("add", 2'b01, 64'd0, 1'b1);
      mid();
      chk("sub1.grant", 128'(bus.req_ready), 128'(2'b10));

      // Sub: 5 - 7 borrows, then 7 - 5
      cyc();
      chk_resp("sub1", 2'b10, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
      bus.req_valid = 2'b10;
      set_req(1, 64'd7, 64'd5, 1'b0, 1'b1, 1'b0);
      mid();
      chk("sub2.grant", 128'(bus.req_ready), 128'(2'b10));
      cyc();
      chk_resp("sub2", 2'b10, 64'd2, 1'b1);

      // Contention: alternating grants, one response per cycle
      bus.req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         set_req(0, 64'(16 + i), 64'd1, 1'b0, 1'b0, 1'b0);
         set_req(1, 64'(32 + i), 64'd2, 1'b0, 1'b0, 1'b0);
         mid();
         chk($sformatf("rr%0d.grant", i), 128'(bus.req_ready),
             128'((i % 2 == 0) ? 2'b01 : 2'b10));
         cyc();
         if (i % 2 == 0) chk_resp($sformatf("rr%0d", i), 2'b01, 64'(17 + i), 1'b0);
         else            chk_resp($sformatf("rr%0d", i), 2'b10, 64'(34 + i), 1'b0);
      end

      // Single req0 beat so requester 1 wins the next tie
      bus.req_valid = 2'b01;
      set_req(0, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
      cyc();
      chk_resp("solo0", 2'b01, 64'd7, 1'b0);

      // Chained add from requester 1 while requester 0 waits
      bus.req_valid = 2'b11;
      set_req(1, ones, 64'd1, 1'b0, 1'b0, 1'b1);
      mid();
      chk("ch0.grant", 128'(bus.req_ready), 128'(2'b10));
      cyc();
      chk_resp("ch0", 2'b10, 64'd0, 1'b1);
      set_req(1, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
      mid();
      chk("ch1.grant", 128'(bus.req_ready), 128'(2'b10));
      cyc();
      chk_resp("ch1", 2'b10, 64'd1, 1'b0);
      bus.req_valid = 2'b01;
      mid();
      chk("after_ch.grant", 128'(bus.req_ready), 128'(2'b01));
      cyc();
      chk_resp("after_ch", 2'b01, 64'd7, 1'b0);

      // Chained sub: continuation beat uses stored carry, not the forced 1
      bus.req_valid = 2'b11;
      set_req(1, 64'd0, 64'd1, 1'b0, 1'b1, 1'b1);
      mid();
      chk("chs0.grant", 128'(bus.req_ready), 128'(2'b10));
      cyc();
      chk_resp("chs0", 2'b10, ones, 1'b0);
      set_req(1, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
      mid();
      chk("chs1.grant", 128'(bus.req_ready), 128'(2'b10));
      cyc();
      chk_resp("chs1", 2'b10, ones, 1'b0);

      // Backpressure on requester 0's result
      bus.req_valid = 2'b01;
      set_req(0, 64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
      cyc();
      chk_resp("bp.load", 2'b01, 64'd30, 1'b0);
      bus.resp_ready = 2'b10;
      set_req(0, 64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         mid();
         chk($sformatf("bp%0d.req_ready", i), 128'(bus.req_ready), 128'(2'b00));
         cyc();
         chk_resp($sformatf("bp%0d.hold", i), 2'b01, 64'd30, 1'b0);
      end
      bus.resp_ready = 2'b11;
      mid();
      chk("bp.drain_accept", 128'(bus.req_ready), 128'(2'b01));
      cyc();
      chk_resp("bp.next", 2'b01, 64'd3, 1'b0);

      // Reset while locked to requester 1
      bus.req_valid = 2'b10;
      set_req(1, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
      cyc();
      chk_resp("lk0", 2'b10, 64'd2, 1'b0);
      bus.req_valid = 2'b11;
      set_req(1, 64'd5, 64'd5, 1'b0, 1'b0, 1'b0);
      set_req(0, 64'd100, 64'd1, 1'b0, 1'b0, 1'b0);
      mid();
      chk("lk1.grant", 128'(bus.req_ready), 128'(2'b10));
      rst_n = 1'b0;
      #1;
      chk("mrst.req_ready",  128'(bus.req_ready),  128'(2'b00));
      chk("mrst.resp_valid", 128'(bus.resp_valid), 128'(2'b00));
      chk("mrst.resp_sum",   128'(bus.resp_sum),   128'(0));
      cyc();
      rst_n = 1'b1;
      mid();
      chk("post_rst.grant", 128'(bus.req_ready), 128'(2'b01));
      cyc();
      chk_resp("post_rst", 2'b01, 64'd101, 1'b0);
      bus.req_valid = 2'b00;
      cyc();
      chk("idle.resp_valid", 128'(bus.resp_valid), 128'(2'b00));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
